// File: rtl/id_operand_scoreboard_pkg.sv
// Shared constants for the decode-stage operand scoreboard.
// Also holds the saturating increment used by the stall-cycle counter.
package id_operand_scoreboard_pkg;

  localparam int XLEN           = 64;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_DATA_DEPTH = 32;
  localparam int FWD_EX         = 0;
  localparam int FWD_MEM        = 1;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

endpackage

// File: rtl/id_operand_scoreboard_operand_sel.sv
// Single-source operand resolver: picks register-file data or the youngest
// matching forward source, and flags a hazard when the value is not available.
module operand_sel
  import id_operand_scoreboard_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int AW   = 5,
  parameter int NFWD = 2
) (
  input  logic [AW-1:0]        rs_i,
  input  logic                 use_i,
  input  logic [XLEN-1:0]      rf_data_i,
  input  logic [NFWD-1:0]      fwd_valid_i,
  input  logic [NFWD-1:0]      fwd_ready_i,
  input  logic [NFWD*AW-1:0]   fwd_addr_i,
  input  logic [NFWD*XLEN-1:0] fwd_data_i,
  input  logic                 pend_nz_i,
  output logic [XLEN-1:0]      data_o,
  output logic                 fwd_o,
  output logic                 hazard_o
);

  logic found_s;

  // Lowest index is youngest, so the first match in the scan wins.
  always_comb begin
    data_o   = '0;
    fwd_o    = 1'b0;
    hazard_o = 1'b0;
    found_s  = 1'b0;
    if (rs_i == '0) begin
      data_o = '0;
    end else if (!pend_nz_i) begin
      data_o = rf_data_i;
    end else begin
      for (int i = FWD_EX; i < NFWD; i++) begin
        if (!found_s && fwd_valid_i[i] && (fwd_addr_i[i*AW +: AW] == rs_i)) begin
          found_s = 1'b1;
          if (fwd_ready_i[i]) begin
            data_o = fwd_data_i[i*XLEN +: XLEN];
            fwd_o  = 1'b1;
          end else begin
            hazard_o = use_i;
          end
        end else begin
          found_s = found_s;
        end
      end
      // Pending but not visible on any forward bus: producer sits beyond the last stage.
      if (!found_s) begin
        hazard_o = use_i;
      end else begin
        hazard_o = hazard_o;
      end
    end
  end

endmodule

// File: rtl/id_operand_scoreboard.sv
// Decode-stage operand scoreboard: per-register in-flight writer counters,
// operand resolution for rs1/rs2, stall/issue generation and a stall-cycle counter.
module id_operand_scoreboard
  import id_operand_scoreboard_pkg::*;
#(
  parameter int XLEN = id_operand_scoreboard_pkg::XLEN,
  parameter int NREG = id_operand_scoreboard_pkg::REG_DATA_DEPTH,
  parameter int AW   = id_operand_scoreboard_pkg::REG_ADDR_WIDTH,
  parameter int NFWD = 2,
  parameter int CW   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [AW-1:0]        id_rs1,
  input  logic [AW-1:0]        id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [AW-1:0]        id_rd,
  input  logic                 id_rd_wen,
  input  logic                 ex_ready,
  input  logic [XLEN-1:0]      rf_rdata1,
  input  logic [XLEN-1:0]      rf_rdata2,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD-1:0]      fwd_ready,
  input  logic [NFWD*AW-1:0]   fwd_addr,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic                 wb_retire,
  input  logic [AW-1:0]        wb_addr,
  input  logic                 kill_valid,
  input  logic [AW-1:0]        kill_addr,
  input  logic                 flush,
  output logic [XLEN-1:0]      op1_data,
  output logic [XLEN-1:0]      op2_data,
  output logic                 op1_fwd,
  output logic                 op2_fwd,
  output logic                 stall,
  output logic                 issue,
  output logic [31:0]          stall_cycles
);

  logic [CW-1:0] pending_q [NREG];
  logic [CW-1:0] pending_d [NREG];
  logic [31:0]   stall_cnt_q;
  logic [31:0]   stall_cnt_d;
  logic [CW:0]   cnt_v;
  logic          hazard1_s, hazard2_s, rd_full_s;

  operand_sel #(.XLEN(XLEN), .AW(AW), .NFWD(NFWD)) u_sel1 (
    .rs_i(id_rs1), .use_i(id_use_rs1), .rf_data_i(rf_rdata1),
    .fwd_valid_i(fwd_valid), .fwd_ready_i(fwd_ready),
    .fwd_addr_i(fwd_addr), .fwd_data_i(fwd_data),
    .pend_nz_i(pending_q[id_rs1] != '0),
    .data_o(op1_data), .fwd_o(op1_fwd), .hazard_o(hazard1_s)
  );

  operand_sel #(.XLEN(XLEN), .AW(AW), .NFWD(NFWD)) u_sel2 (
    .rs_i(id_rs2), .use_i(id_use_rs2), .rf_data_i(rf_rdata2),
    .fwd_valid_i(fwd_valid), .fwd_ready_i(fwd_ready),
    .fwd_addr_i(fwd_addr), .fwd_data_i(fwd_data),
    .pend_nz_i(pending_q[id_rs2] != '0),
    .data_o(op2_data), .fwd_o(op2_fwd), .hazard_o(hazard2_s)
  );

  assign rd_full_s    = id_rd_wen && (id_rd != '0) && (pending_q[id_rd] == {CW{1'b1}});
  assign stall        = id_valid && (hazard1_s || hazard2_s || rd_full_s);
  assign issue        = id_valid && !stall && ex_ready && !flush;
  assign stall_cycles = stall_cnt_q;

  // Next-state for every counter: apply the issue increment first, then each
  // decrement, so +1/-1 cancel and a decrement of an empty counter is dropped.
  always_comb begin
    cnt_v = '0;
    for (int r = 0; r < NREG; r++) begin
      if (r == 0) begin
        pending_d[r] = '0;
      end else begin
        cnt_v = {1'b0, pending_q[r]};
        if (issue && id_rd_wen && (id_rd == AW'(r))) begin
          cnt_v = cnt_v + {{CW{1'b0}}, 1'b1};
        end else begin
          cnt_v = cnt_v;
        end
        if (wb_retire && (wb_addr == AW'(r)) && (cnt_v != '0)) begin
          cnt_v = cnt_v - {{CW{1'b0}}, 1'b1};
        end else begin
          cnt_v = cnt_v;
        end
        if (kill_valid && (kill_addr == AW'(r)) && (cnt_v != '0)) begin
          cnt_v = cnt_v - {{CW{1'b0}}, 1'b1};
        end else begin
          cnt_v = cnt_v;
        end
        pending_d[r] = cnt_v[CW-1:0];
      end
    end
  end

  // Saturating stall-cycle counter next state.
  always_comb begin
    if (stall) begin
      stall_cnt_d = sat_inc32(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Counter array and performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        pending_q[r] <= '0;
      end
      stall_cnt_q <= 32'd0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        pending_q[r] <= pending_d[r];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_id_operand_scoreboard.sv
// Directed bench for id_operand_scoreboard: expectations are queued as each
// cycle's stimulus is driven, then popped and compared against the outputs.
module tb_id_operand_scoreboard;

  localparam logic [63:0] RF1 = 64'h0000_0000_AAAA_0001;
  localparam logic [63:0] RF2 = 64'h0000_0000_BBBB_0002;

  logic         clk, rst_n;
  logic         id_valid, id_use_rs1, id_use_rs2, id_rd_wen, ex_ready;
  logic [4:0]   id_rs1, id_rs2, id_rd, wb_addr, kill_addr;
  logic [63:0]  rf_rdata1, rf_rdata2;
  logic [1:0]   fwd_valid, fwd_ready;
  logic [9:0]   fwd_addr;
  logic [127:0] fwd_data;
  logic         wb_retire, kill_valid, flush;
  logic [63:0]  op1_data, op2_data;
  logic         op1_fwd, op2_fwd, stall, issue;
  logic [31:0]  stall_cycles;

  typedef struct {
    string       tag;
    logic [63:0] op1, op2;
    logic        f1, f2, st, is, cop;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_cnt = 32'd0;

  id_operand_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_rd_wen(id_rd_wen),
    .ex_ready(ex_ready), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .wb_retire(wb_retire), .wb_addr(wb_addr), .kill_valid(kill_valid), .kill_addr(kill_addr),
    .flush(flush), .op1_data(op1_data), .op2_data(op2_data), .op1_fwd(op1_fwd),
    .op2_fwd(op2_fwd), .stall(stall), .issue(issue), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_rd = 5'd0; id_rd_wen = 1'b0; ex_ready = 1'b1;
    rf_rdata1 = RF1; rf_rdata2 = RF2;
    fwd_valid = 2'b00; fwd_ready = 2'b00; fwd_addr = 10'd0; fwd_data = 128'd0;
    wb_retire = 1'b0; wb_addr = 5'd0; kill_valid = 1'b0; kill_addr = 5'd0; flush = 1'b0;
  endtask

  task automatic instr(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic wen);
    id_valid = 1'b1; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_rd_wen = wen;
  endtask

  task automatic set_fwd(input int idx, input logic [4:0] a, input logic [63:0] d, input logic rdy);
    fwd_valid[idx] = 1'b1;
    fwd_ready[idx] = rdy;
    fwd_addr[idx*5 +: 5] = a;
    fwd_data[idx*64 +: 64] = d;
  endtask

  // Queue this cycle's expectation, compare the combinational outputs, then the
  // stall counter after the clock edge; cop=0 leaves operand data/fwd unchecked.
  task automatic step(input string tag, input logic [63:0] e1, input logic f1,
                      input logic [63:0] e2, input logic f2, input logic st,
                      input logic is, input logic cop);
    exp_t e;
    e.tag = tag; e.op1 = e1; e.op2 = e2; e.f1 = f1; e.f2 = f2;
    e.st = st; e.is = is; e.cop = cop;
    exp_q.push_back(e);
    #2;
    e = exp_q.pop_front();
    if (e.cop) begin
      chk({e.tag, ":op1_data"}, op1_data, e.op1);
      chk({e.tag, ":op1_fwd"}, {63'd0, op1_fwd}, {63'd0, e.f1});
      chk({e.tag, ":op2_data"}, op2_data, e.op2);
      chk({e.tag, ":op2_fwd"}, {63'd0, op2_fwd}, {63'd0, e.f2});
    end
    chk({e.tag, ":stall"}, {63'd0, stall}, {63'd0, e.st});
    chk({e.tag, ":issue"}, {63'd0, issue}, {63'd0, e.is});
    @(posedge clk);
    #1;
    if (!rst_n) exp_cnt = 32'd0;
    else if (e.st) exp_cnt = exp_cnt + 32'd1;
    chk({e.tag, ":stall_cycles"}, {32'd0, stall_cycles}, {32'd0, exp_cnt});
    @(negedge clk);
    clr_in();
  endtask

  initial begin
    clr_in();
    rst_n = 1'b0;
    step("reset", 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;

    instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
    step("add_x5", RF1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    instr(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); set_fwd(0, 5'd5, 64'h1234, 1'b1);
    wb_retire = 1'b1; wb_addr = 5'd5;
    step("fwd_ex", 64'h1234, 1'b1, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    step("load_x7", 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); set_fwd(0, 5'd7, 64'd0, 1'b0);
    step("load_use", 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    instr(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); set_fwd(1, 5'd7, 64'hDEAD, 1'b1);
    wb_retire = 1'b1; wb_addr = 5'd7;
    step("fwd_mem", 64'hDEAD, 1'b1, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 2; i++) begin
      instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
      step("w3", 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    instr(5'd3, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0);
    set_fwd(0, 5'd3, 64'hA, 1'b1); set_fwd(1, 5'd3, 64'hB, 1'b1);
    wb_retire = 1'b1; wb_addr = 5'd3;
    step("youngest", 64'hA, 1'b1, 64'hA, 1'b1, 1'b0, 1'b1, 1'b1);
    wb_retire = 1'b1; wb_addr = 5'd3;
    step("idle_ret3", 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    step("w9", 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1); wb_retire = 1'b1; wb_addr = 5'd9;
    step("w9_ret9", 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    instr(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); wb_retire = 1'b1; wb_addr = 5'd9;
    step("x9_pend", 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    instr(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step("x9_rf", RF1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
    step("w4", 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); flush = 1'b1; kill_valid = 1'b1; kill_addr = 5'd4;
    step("flush", RF1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    instr(5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    step("x4_rf", RF1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    instr(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); set_fwd(0, 5'd0, 64'h5555, 1'b1);
    step("x0_fwd", 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 3; i++) begin
      instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1);
      step("w6", 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1);
    step("w6_full", 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1); wb_retire = 1'b1; wb_addr = 5'd6;
    step("w6_full_ret", 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    instr(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1);
    step("w6_go", 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    instr(5'd0, 1'b0, 5'd6, 1'b0, 5'd0, 1'b0);
    step("rs2_unused", 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    instr(5'd0, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0); set_fwd(1, 5'd6, 64'h66, 1'b1);
    step("rs2_fwd_mem", 64'd0, 1'b0, 64'h66, 1'b1, 1'b0, 1'b1, 1'b1);
    instr(5'd0, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0);
    step("rs2_hazard", 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    instr(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0); ex_ready = 1'b0;
    step("no_ready", RF1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    rst_n = 1'b0;
    step("midrst", 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    instr(5'd6, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0);
    step("post_rst", RF1, 1'b0, RF2, 1'b0, 1'b0, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
